// File: rtl/imm_gen_sequencer.sv
// Feeds the registered immediate generator from raw RV32I instructions and holds
// the result behind a valid/ready handshake. Optional: IMM_SEQ_SELFCHECK_EN.
module imm_gen_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [6:0]  gen_opcode,
  output logic [19:0] gen_inx20,
  output logic [11:0] gen_inx12,
  output logic        gen_enx20,
  output logic        gen_enx12,
  output logic        gen_shamt,
  input  logic [31:0] gen_out,
  output logic        imm_valid,
  input  logic        imm_ready,
  output logic [31:0] imm,
  output logic [2:0]  imm_fmt,
  output logic        chk_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0, FMT_I = 3'd1, FMT_SHAMT = 3'd2, FMT_S = 3'd3,
    FMT_B = 3'd4, FMT_U = 3'd5, FMT_J = 3'd6
  } fmt_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  state_t      state;
  fmt_t        fmt_q;
  fmt_t        in_fmt;
  logic [19:0] nx_inx20;
  logic [11:0] nx_inx12;
  logic        accept;

  // Reset gating keeps the fetch side stalled while rst_n is held low.
  assign instr_ready = rst_n & ((state == IDLE) | ((state == HOLD) & imm_ready));
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    in_fmt = FMT_NONE;
    case (instr[6:0])
      OP_LUI, OP_AUIPC:  in_fmt = FMT_U;
      OP_JAL:            in_fmt = FMT_J;
      OP_IMM:            in_fmt = (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                                  ? FMT_SHAMT : FMT_I;
      OP_LOAD, OP_JALR:  in_fmt = FMT_I;
      OP_STORE:          in_fmt = FMT_S;
      OP_BRANCH:         in_fmt = FMT_B;
      default:           in_fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    nx_inx20 = '0;
    nx_inx12 = '0;
    case (in_fmt)
      FMT_U, FMT_J:     nx_inx20 = instr[31:12];
      FMT_I, FMT_SHAMT: nx_inx12 = instr[31:20];
      FMT_S, FMT_B:     nx_inx12 = {instr[31:25], instr[11:7]};
      default:          ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      fmt_q      <= FMT_NONE;
      gen_opcode <= '0;
      gen_inx20  <= '0;
      gen_inx12  <= '0;
      gen_enx20  <= 1'b0;
      gen_enx12  <= 1'b0;
      gen_shamt  <= 1'b0;
      imm_valid  <= 1'b0;
      imm        <= '0;
      imm_fmt    <= '0;
    end else begin
      unique case (state)
        // IDLE and HOLD share the accept path so a release and a new accept
        // can land on the same edge.
        IDLE, HOLD: begin
          if (accept) begin
            gen_opcode <= instr[6:0];
            gen_inx20  <= nx_inx20;
            gen_inx12  <= nx_inx12;
            fmt_q      <= in_fmt;
            if (in_fmt == FMT_NONE) begin
              state     <= HOLD;
              imm       <= '0;
              imm_fmt   <= '0;
              imm_valid <= 1'b1;
            end else begin
              state     <= ISSUE;
              gen_enx20 <= (in_fmt == FMT_U) || (in_fmt == FMT_J);
              gen_enx12 <= (in_fmt == FMT_I) || (in_fmt == FMT_S) || (in_fmt == FMT_B);
              gen_shamt <= (in_fmt == FMT_SHAMT);
              imm_valid <= 1'b0;
            end
          end else if (state == HOLD && imm_ready) begin
            state      <= IDLE;
            imm_valid  <= 1'b0;
            gen_opcode <= '0;
            gen_inx20  <= '0;
            gen_inx12  <= '0;
          end
        end
        ISSUE: begin
          gen_enx20 <= 1'b0;
          gen_enx12 <= 1'b0;
          gen_shamt <= 1'b0;
          state     <= CAPTURE;
        end
        CAPTURE: begin
          imm       <= gen_out;
          imm_fmt   <= fmt_q;
          imm_valid <= 1'b1;
          state     <= HOLD;
        end
      endcase
    end
  end

`ifdef IMM_SEQ_SELFCHECK_EN
  logic [31:0] ref_imm;

  // Rebuilds the architectural immediate from the held generator fields.
  always_comb begin
    ref_imm = '0;
    case (fmt_q)
      FMT_I, FMT_S: ref_imm = {{20{gen_inx12[11]}}, gen_inx12};
      FMT_SHAMT:    ref_imm = {27'd0, gen_inx12[4:0]};
      FMT_B:        ref_imm = {{19{gen_inx12[11]}}, gen_inx12[11], gen_inx12[0],
                               gen_inx12[10:5], gen_inx12[4:1], 1'b0};
      FMT_U:        ref_imm = {gen_inx20, 12'd0};
      FMT_J:        ref_imm = {{11{gen_inx20[19]}}, gen_inx20[19], gen_inx20[7:0],
                               gen_inx20[8], gen_inx20[18:9], 1'b0};
      default:      ref_imm = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      chk_err <= 1'b0;
    else if (state == CAPTURE && gen_out != ref_imm)
      chk_err <= 1'b1;
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen_sequencer.sv
// Bench for imm_gen_sequencer: directed steps plus a randomized stream scored
// against an instruction-level immediate model; the generator is modelled here.
module tb_imm_gen_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] instr = '0;
  logic [6:0]  gen_opcode;
  logic [19:0] gen_inx20;
  logic [11:0] gen_inx12;
  logic        gen_enx20, gen_enx12, gen_shamt;
  logic [31:0] gen_out = '0;
  logic        imm_valid;
  logic        imm_ready = 1'b0;
  logic [31:0] imm;
  logic [2:0]  imm_fmt;
  logic        chk_err;

  logic        gen_zero = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
  } exp_t;
  exp_t q[$];

  imm_gen_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .gen_opcode(gen_opcode), .gen_inx20(gen_inx20), .gen_inx12(gen_inx12),
    .gen_enx20(gen_enx20), .gen_enx12(gen_enx12), .gen_shamt(gen_shamt),
    .gen_out(gen_out), .imm_valid(imm_valid), .imm_ready(imm_ready), .imm(imm),
    .imm_fmt(imm_fmt), .chk_err(chk_err)
  );

  always #5 clk = ~clk;

  // Registered immediate generator sitting beside the sequencer.
  always @(posedge clk) begin
    if (gen_enx20 || gen_enx12 || gen_shamt) begin
      if (gen_zero)
        gen_out <= '0;
      else if (gen_enx20)
        gen_out <= (gen_opcode == 7'h6F)
          ? {{11{gen_inx20[19]}}, gen_inx20[19], gen_inx20[7:0], gen_inx20[8], gen_inx20[18:9], 1'b0}
          : {gen_inx20, 12'd0};
      else if (gen_shamt)
        gen_out <= {27'd0, gen_inx12[4:0]};
      else
        gen_out <= (gen_opcode == 7'h63)
          ? {{19{gen_inx12[11]}}, gen_inx12[11], gen_inx12[0], gen_inx12[10:5], gen_inx12[4:1], 1'b0}
          : {{20{gen_inx12[11]}}, gen_inx12};
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] ref_fmt(input logic [31:0] i);
    case (i[6:0])
      7'h37, 7'h17: return 3'd5;
      7'h6F:        return 3'd6;
      7'h13:        return (i[14:12] == 3'd1 || i[14:12] == 3'd5) ? 3'd2 : 3'd1;
      7'h03, 7'h67: return 3'd1;
      7'h23:        return 3'd3;
      7'h63:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (ref_fmt(i))
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {27'd0, i[24:20]};
      3'd3:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd4:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd5:    return {i[31:12], 12'd0};
      3'd6:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h13, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h33};
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 9)];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction from IDLE or HOLD and follows it into HOLD.
  task automatic run_instr(input logic [31:0] ins, input logic [31:0] eimm, input logic [2:0] efmt);
    logic [2:0] f;
    f = ref_fmt(ins);
    instr = ins;
    instr_valid = 1'b1;
    imm_ready = 1'b1;
    #1 check("acc_ready", 32'(instr_ready), 1);
    step();
    instr_valid = 1'b0;
    imm_ready = 1'b0;
    check("opcode", 32'(gen_opcode), 32'(ins[6:0]));
    if (f == 3'd0) begin
      check("none_en", 32'({gen_enx20, gen_enx12, gen_shamt}), 0);
    end else begin
      check("issue_en", 32'({gen_enx20, gen_enx12, gen_shamt}),
            32'({f >= 3'd5, (f == 3'd1 || f == 3'd3 || f == 3'd4), f == 3'd2}));
      if (f >= 3'd5)
        check("inx20", 32'(gen_inx20), 32'(ins[31:12]));
      else
        check("inx12", 32'(gen_inx12), (f <= 3'd2) ? 32'(ins[31:20]) : 32'({ins[31:25], ins[11:7]}));
      check("issue_valid", 32'(imm_valid), 0);
      step();
      check("capture_en", 32'({gen_enx20, gen_enx12, gen_shamt}), 0);
      check("capture_valid", 32'(imm_valid), 0);
      step();
    end
    check("hold_valid", 32'(imm_valid), 1);
    check("imm", imm, eimm);
    check("imm_fmt", 32'(imm_fmt), 32'(efmt));
  endtask

  task automatic release_hold();
    imm_ready = 1'b1;
    instr_valid = 1'b0;
    step();
    check("rel_valid", 32'(imm_valid), 0);
    check("rel_fields", 32'({gen_opcode, gen_inx12}) | 32'(gen_inx20), 0);
    imm_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] nones [4] = '{32'h00000073, 32'h0000000F, 32'h002081B3, 32'h40208233};
    exp_t        e;

    // Reset held two cycles with an instruction on offer
    rst_n = 1'b0;
    instr_valid = 1'b1;
    instr = 32'hFFF00093;
    step();
    step();
    check("rst_ready", 32'(instr_ready), 0);
    check("rst_gen", 32'({gen_opcode, gen_inx12, gen_enx20, gen_enx12, gen_shamt}), 0);
    check("rst_inx20", 32'(gen_inx20), 0);
    check("rst_out", 32'({imm_valid, imm_fmt, chk_err}), 0);
    check("rst_imm", imm, 0);
    rst_n = 1'b1;
    instr_valid = 1'b0;
    #1 check("rel_ready", 32'(instr_ready), 1);
    step();

    // Directed generator-type instructions
    run_instr(32'hFFF00093, 32'hFFFFFFFF, 3'd1);
    release_hold();
    run_instr(32'h40315093, 32'h00000003, 3'd2);
    release_hold();
    run_instr(32'hFE000EE3, 32'hFFFFFFFC, 3'd4);
    release_hold();
    run_instr(32'hFE112C23, 32'hFFFFFFF8, 3'd3);
    release_hold();
    run_instr(32'h0040006F, 32'h00000004, 3'd6);
    release_hold();
    run_instr(32'h123450B7, 32'h12345000, 3'd5);

    // Backpressure: HOLD frozen, competing instruction ignored
    instr_valid = 1'b1;
    instr = 32'hFE000EE3;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_ready", 32'(instr_ready), 0);
      check("bp_valid", 32'(imm_valid), 1);
      check("bp_imm", imm, 32'h12345000);
      check("bp_fmt", 32'(imm_fmt), 5);
      check("bp_en", 32'({gen_enx20, gen_enx12, gen_shamt}), 0);
    end
    // Same-edge release and accept
    run_instr(32'hFE000EE3, 32'hFFFFFFFC, 3'd4);
    release_hold();

    // NONE: single, then back-to-back at one per cycle
    run_instr(32'h002081B3, 32'h00000000, 3'd0);
    imm_ready = 1'b1;
    instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = nones[k];
      #1 check("none_ready", 32'(instr_ready), 1);
      step();
      check("none_valid", 32'(imm_valid), 1);
      check("none_opcode", 32'(gen_opcode), 32'(nones[k][6:0]));
      check("none_imm", imm | 32'(imm_fmt), 0);
      check("none_en", 32'({gen_enx20, gen_enx12, gen_shamt}), 0);
    end
    release_hold();

    // Generator throughput: one accept every third cycle
    instr = 32'hFFF00093;
    instr_valid = 1'b1;
    imm_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1 check("tput_ready", 32'(instr_ready), 32'(k % 3 == 0));
      step();
    end
    check("tput_imm", imm, 32'hFFFFFFFF);
    release_hold();

    // Reset during ISSUE discards the instruction
    instr = 32'hFFF00093;
    instr_valid = 1'b1;
    step();
    check("pre_rst_en", 32'(gen_enx12), 1);
    rst_n = 1'b0;
    instr_valid = 1'b0;
    step();
    check("midrst_gen", 32'({gen_opcode, gen_inx12, gen_enx20, gen_enx12, gen_shamt}) | 32'(gen_inx20), 0);
    check("midrst_valid", 32'(imm_valid), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst_quiet", 32'({gen_enx20, gen_enx12, gen_shamt, imm_valid}), 0);
    end

    // Randomized stream against the instruction-level model
    for (int c = 0; c < 400; c++) begin
      instr_valid = ($urandom_range(0, 3) != 0);
      instr = rand_instr();
      imm_ready = ($urandom_range(0, 3) != 0);
      #2;
      if (imm_valid && imm_ready) begin
        check("sb_depth", q.size(), 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("rnd_imm", imm, e.imm);
          check("rnd_fmt", 32'(imm_fmt), 32'(e.fmt));
        end
      end
      if (instr_valid && instr_ready) begin
        e.imm = ref_imm(instr);
        e.fmt = ref_fmt(instr);
        q.push_back(e);
      end
      step();
    end
    instr_valid = 1'b0;
    imm_ready = 1'b1;
    for (int c = 0; c < 8 && q.size() > 0; c++) begin
      #2;
      if (imm_valid) begin
        e = q.pop_front();
        check("drain_imm", imm, e.imm);
        check("drain_fmt", 32'(imm_fmt), 32'(e.fmt));
      end
      step();
    end
    check("drain_empty", q.size(), 0);
    step();
    imm_ready = 1'b0;
    check("chk_clean", 32'(chk_err), 0);

`ifdef IMM_SEQ_SELFCHECK_EN
    gen_zero = 1'b1;
    run_instr(32'hFFF00093, 32'h00000000, 3'd1);
    check("chk_set", 32'(chk_err), 1);
    gen_zero = 1'b0;
    release_hold();
    step();
    check("chk_sticky", 32'(chk_err), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("chk_rst", 32'(chk_err), 0);
`else
    run_instr(32'h00100093, 32'h00000001, 3'd1);
    release_hold();
    check("chk_tied", 32'(chk_err), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
